// File: rtl/cmd_pipe_arbiter_pkg.sv
// Shared command codes and arbiter state encodings for cmd_pipe_arbiter.
package cmd_pipe_arbiter_pkg;

    localparam logic [3:0] COMM_NOP    = 4'h0;
    localparam logic [3:0] COMM_FINISH = 4'hF;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_RUN   = 2'd1,
        ARB_FLUSH = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cmd_rr_grant.sv
// Round-robin grant: first requester at or after ptr (modulo N_SRC).
// Purely combinational; gnt is one-hot or zero, index is the granted source.
module cmd_rr_grant #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned SRC_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [SRC_W-1:0] ptr,
    output logic [N_SRC-1:0] gnt,
    output logic [SRC_W-1:0] index
);

    logic             found;
    int unsigned      pos;
    logic [SRC_W-1:0] pos_w;

    // Scan sources starting at ptr, wrapping, and pick the first requester.
    always_comb begin
        gnt   = '0;
        index = '0;
        found = 1'b0;
        pos   = 0;
        pos_w = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            pos   = (32'(ptr) + k) % N_SRC;
            pos_w = SRC_W'(pos);
            if (!found && req[pos_w]) begin
                found      = 1'b1;
                gnt[pos_w] = 1'b1;
                index      = pos_w;
            end
        end
    end

endmodule

// File: rtl/cmd_pipe_arbiter.sv
// Merges N_SRC command pipes into one 32-bit command stream.
// Round-robin fair, drops NOP beats, collapses per-source FINISH into one final FINISH.
// Optional macro CMDARB_SRCID_EN: forwarded beats carry the source index in [31:24].
module cmd_pipe_arbiter
    import cmd_pipe_arbiter_pkg::*;
#(
    parameter  int unsigned N_SRC = 4,
    localparam int unsigned SRC_W = $clog2(N_SRC)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                done,
    input  logic [32*N_SRC-1:0] s_tdata,
    input  logic [N_SRC-1:0]    s_tvalid,
    output logic [N_SRC-1:0]    s_tready,
    output logic [31:0]         m_tdata,
    output logic                m_tvalid,
    input  logic                m_tready
);

    arb_state_t       state;
    logic [SRC_W-1:0] rr_ptr;
    logic [N_SRC-1:0] fin_mask;

    logic             slot_free;
    logic             grant_en;
    logic [N_SRC-1:0] gnt;
    logic [SRC_W-1:0] gnt_idx;
    logic [31:0]      beat;
    logic [3:0]       cmd;
    logic [N_SRC-1:0] fin_next;
    logic             last_fin;
    logic [31:0]      fwd_data;
    logic [SRC_W-1:0] rr_next;

    cmd_rr_grant #(
        .N_SRC (N_SRC),
        .SRC_W (SRC_W)
    ) u_grant (
        .req   (s_tvalid & ~fin_mask),
        .ptr   (rr_ptr),
        .gnt   (gnt),
        .index (gnt_idx)
    );

    // Grant qualification, granted beat selection and forwarded data formatting.
    always_comb begin
        slot_free = !m_tvalid || m_tready;
        grant_en  = (state == ARB_RUN) && slot_free;
        s_tready  = grant_en ? gnt : '0;
        beat      = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (gnt[k]) beat = s_tdata[32*k +: 32];
        end
        cmd      = beat[3:0];
        fin_next = fin_mask | gnt;
        last_fin = &fin_next;
        rr_next  = (gnt_idx == SRC_W'(N_SRC - 1)) ? '0 : gnt_idx + 1'b1;
`ifdef CMDARB_SRCID_EN
        fwd_data = {{(8-SRC_W){1'b0}}, gnt_idx, beat[23:0]};
`else
        fwd_data = beat;
`endif
    end

    // Arbitration FSM with the single output register slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            done     <= 1'b1;
            rr_ptr   <= '0;
            fin_mask <= '0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
        end else begin
            // Slot drains on handshake; a load below in the same cycle overrides.
            if (m_tvalid && m_tready) m_tvalid <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    done <= 1'b1;
                    if (start) begin
                        state    <= ARB_RUN;
                        done     <= 1'b0;
                        fin_mask <= '0;
                        rr_ptr   <= '0;
                    end
                end
                ARB_RUN: begin
                    if (|s_tready) begin
                        rr_ptr <= rr_next;
                        if (cmd == COMM_FINISH) begin
                            fin_mask <= fin_next;
                            if (last_fin) begin
                                m_tdata  <= fwd_data;
                                m_tvalid <= 1'b1;
                                state    <= ARB_FLUSH;
                            end
                        end else if (cmd != COMM_NOP) begin
                            m_tdata  <= fwd_data;
                            m_tvalid <= 1'b1;
                        end
                    end
                end
                ARB_FLUSH: begin
                    if (m_tvalid && m_tready) begin
                        state <= ARB_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state    <= ARB_IDLE;
                    done     <= 1'b1;
                    m_tvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_pipe_arbiter.sv
// Self-checking bench for cmd_pipe_arbiter: directed scenarios plus randomized runs,
// checked every cycle against a behavioural model of the arbitration rules.
module tb_cmd_pipe_arbiter;

    localparam int unsigned N = 4;
`ifdef CMDARB_SRCID_EN
    localparam bit SRCID = 1'b1;
`else
    localparam bit SRCID = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           done;
    logic [32*N-1:0] s_tdata;
    logic [N-1:0]   s_tvalid;
    logic [N-1:0]   s_tready;
    logic [31:0]    m_tdata;
    logic           m_tvalid;
    logic           m_tready;

    always #5 clk = ~clk;

    cmd_pipe_arbiter #(.N_SRC(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .done     (done),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          mstate = 0;   // 0 idle, 1 run, 2 flush
    int          mptr   = 0;
    logic [N-1:0] mfin  = '0;
    logic        mvalid = 1'b0;
    logic [31:0] mdata  = '0;
    int          mg;
    logic [N-1:0] exp_rdy;
    logic [31:0] gdat;

    function automatic int pick(input int ptr, input logic [N-1:0] fin, input logic [N-1:0] vld);
        for (int k = 0; k < int'(N); k++) begin
            int j;
            j = (ptr + k) % int'(N);
            if (vld[j] && !fin[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [31:0] fwd(input logic [31:0] d, input int src);
        if (SRCID) return {8'(src), d[23:0]};
        return d;
    endfunction

    always_comb begin
        mg = -1;
        if (mstate == 1 && (!mvalid || m_tready)) mg = pick(mptr, mfin, s_tvalid);
        exp_rdy = (mg >= 0) ? ((N)'(1) << mg) : '0;
        gdat = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (exp_rdy[k]) gdat = s_tdata[32*k +: 32];
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            mstate <= 0; mptr <= 0; mfin <= '0; mvalid <= 1'b0; mdata <= '0;
        end else begin
            case (mstate)
                0: if (start) begin mstate <= 1; mptr <= 0; mfin <= '0; end
                1: begin
                    if (mvalid && m_tready) mvalid <= 1'b0;
                    if (mg >= 0) begin
                        mptr <= (mg + 1) % int'(N);
                        if (gdat[3:0] == 4'hF) begin
                            mfin <= mfin | exp_rdy;
                            if (&(mfin | exp_rdy)) begin
                                mvalid <= 1'b1; mdata <= fwd(gdat, mg); mstate <= 2;
                            end
                        end else if (gdat[3:0] != 4'h0) begin
                            mvalid <= 1'b1; mdata <= fwd(gdat, mg);
                        end
                    end
                end
                2: if (mvalid && m_tready) begin mvalid <= 1'b0; mstate <= 0; end
                default: mstate <= 0;
            endcase
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("s_tready", 32'(s_tready), 32'(exp_rdy));
            check("m_tvalid", 32'(m_tvalid), 32'(mvalid));
            check("m_tdata",  m_tdata, mdata);
            check("done",     32'(done), 32'(mstate == 0));
        end
    end

    // ---------------- stimulus ----------------
    logic [N-1:0] acc_q;
    always @(negedge clk) acc_q <= s_tready & s_tvalid;

    // Advance one edge; sources whose beat was just accepted drop valid.
    task automatic step();
        @(posedge clk);
        #1;
        s_tvalid = s_tvalid & ~acc_q;
    endtask

    task automatic set_src(input int i, input logic [31:0] d);
        s_tdata[32*i +: 32] = d;
        s_tvalid[i] = 1'b1;
    endtask

    function automatic logic [31:0] rand_beat(input int cyc);
        logic [31:0] d;
        int r;
        d = $urandom;
        r = $urandom_range(0, 15);
        if (cyc >= 150 || r == 15) d[3:0] = 4'hF;
        else if (r < 3) d[3:0] = 4'h0;
        return d;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit finished;
        rst_n = 1'b0; start = 1'b0; m_tready = 1'b0;
        s_tvalid = '0; s_tdata = '0;
        step(); step();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_done",   32'(done), 32'd1);
        check("rst_mvalid", 32'(m_tvalid), 32'd0);
        check("rst_sready", 32'(s_tready), 32'd0);
        check("rst_mdata",  m_tdata, 32'd0);

        // 1: src0 and src2 together, drained on consecutive cycles
        step(); rst_n = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        set_src(0, 32'h1); set_src(2, 32'h2); m_tready = 1'b1;
        @(negedge clk);
        check("t1_first_grant", 32'(s_tready), 32'b0001);
        step(); @(negedge clk);
        check("t1_beat0", m_tdata, 32'h1);
        check("t1_valid0", 32'(m_tvalid), 32'd1);
        step(); @(negedge clk);
        check("t1_beat1", m_tdata, SRCID ? 32'h02000002 : 32'h2);
        step(); @(negedge clk);
        check("t1_drained", 32'(m_tvalid), 32'd0);

        // 2: back-pressure holds the slot and blocks further grants
        step(); set_src(1, 32'h5); m_tready = 1'b0;
        step(); set_src(1, 32'h6);
        repeat (5) begin
            @(negedge clk);
            check("t2_hold_valid", 32'(m_tvalid), 32'd1);
            check("t2_hold_data", m_tdata, SRCID ? 32'h01000005 : 32'h5);
            check("t2_no_ready", 32'(s_tready), 32'd0);
            step();
        end
        m_tready = 1'b1;
        step(); @(negedge clk);
        check("t2_next_beat", m_tdata, SRCID ? 32'h01000006 : 32'h6);

        // 3: three FINISHes vanish, the fourth is forwarded once
        step(); set_src(0, 32'hF); set_src(1, 32'hF); set_src(2, 32'hF);
        repeat (3) begin
            @(negedge clk);
            check("t3_no_fwd", 32'(m_tvalid), 32'd0);
            step();
        end
        @(negedge clk);
        check("t3_all_masked", 32'(s_tready), 32'd0);
        step(); set_src(3, 32'hF);
        @(negedge clk);
        check("t3_last_grant", 32'(s_tready), 32'b1000);
        step(); @(negedge clk);
        check("t3_fin_valid", 32'(m_tvalid), 32'd1);
        check("t3_fin_data", m_tdata, SRCID ? 32'h0300000F : 32'hF);
        check("t3_busy", 32'(done), 32'd0);
        step(); @(negedge clk);
        check("t3_done", 32'(done), 32'd1);

        // 4: finished source is locked out; NOP consumed silently
        step(); start = 1'b1;
        step(); start = 1'b0; set_src(3, 32'hF);
        step(); set_src(3, 32'h3);
        repeat (3) begin
            @(negedge clk);
            check("t4_locked", 32'(s_tready), 32'd0);
            step();
        end
        set_src(0, 32'h0);
        @(negedge clk);
        check("t4_nop_grant", 32'(s_tready), 32'b0001);
        step(); @(negedge clk);
        check("t4_nop_dropped", 32'(m_tvalid), 32'd0);

        // 5: reset while a beat is in flight
        step(); set_src(1, 32'h7); m_tready = 1'b0;
        step(); @(negedge clk);
        check("t5_inflight", 32'(m_tvalid), 32'd1);
        step(); rst_n = 1'b0;
        step(); @(negedge clk);
        check("t5_rst_valid", 32'(m_tvalid), 32'd0);
        check("t5_rst_ready", 32'(s_tready), 32'd0);
        check("t5_rst_done", 32'(done), 32'd1);

        // 6: source id stamping
        step(); rst_n = 1'b1; s_tvalid = '0; start = 1'b1; m_tready = 1'b1;
        step(); start = 1'b0; set_src(2, 32'h0000000D);
        step(); @(negedge clk);
        check("t6_srcid", m_tdata, SRCID ? 32'h0200000D : 32'h0000000D);
        step();

        // Randomized runs, each ended by every source finishing
        for (int r = 0; r < 6; r++) begin
            if (done) begin start = 1'b1; step(); start = 1'b0; end
            finished = 1'b0;
            for (int c = 0; c < 400 && !finished; c++) begin
                m_tready = ($urandom_range(0, 3) != 0);
                start    = ($urandom_range(0, 7) == 0);
                for (int i = 0; i < int'(N); i++) begin
                    if (!s_tvalid[i] && $urandom_range(0, 2) == 0) set_src(i, rand_beat(c));
                end
                step();
                if (done) finished = 1'b1;
            end
            start = 1'b0;
            check("run_completes", 32'(finished), 32'd1);
            s_tvalid = '0;
        end

        step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
